mem_responder: RTL and testbench

//  Memory-side responder for the datapath's MAR/MDR memory interface. Accepts a read or

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_ram_sp.sv | 27 ++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: FSM state encodings and default latencies.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RD_LAT   = 2;
    localparam int DEF_WR_LAT   = 1;
    localparam int DEF_PROT_TOP = 15;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_responder_ram_sp.sv
// ram_sp: single-port synchronous RAM, DATA_W x 2**ADDR_W, registered read, no reset.
module ram_sp #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // dout only changes on a read access, so it holds the last read word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= din_i;
            end else begin
                dout_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder for the MAR/MDR interface.
// Optional write protection of addresses 0..PROT_TOP is enabled with `define MEM_PROT_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int WR_LAT   = DEF_WR_LAT,
    parameter int PROT_TOP = DEF_PROT_TOP
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [1:0]        state_o
);

    // Handshake: read/write are levels sampled at the rising edge. A request is
    // accepted only when armed; armed re-sets on any edge with both strobes low, so
    // the requester must drop the strobe for at least one cycle between requests.
    // busy covers accept+1 through the done cycle; done and fault are 1-cycle pulses.

    localparam int MAX_LAT = max_int(RD_LAT, WR_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0]  RD_CNT    = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  WR_CNT    = CNT_W'(WR_LAT - 1);
    localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_TOP);
`ifdef MEM_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              op_rd_q, op_rd_d;
    logic              fault_q, fault_d;

    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic              accept;
    logic              conflict;
    logic              prot_hit;

    assign accept   = armed_q && (read ^ write);
    assign conflict = armed_q && read && write;
    assign prot_hit = PROT_EN && (addr_q <= PROT_ADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_rd_d = op_rd_q;
        fault_d = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 1'b0;

        if (!read && !write) begin
            armed_d = 1'b1;
        end else if (state_q == ST_IDLE && armed_q) begin
            armed_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_rd_d = read;
                    cnt_d   = read ? RD_CNT : WR_CNT;
                    state_d = read ? ST_RD_WAIT : ST_WR_WAIT;
                end else if (conflict) begin
                    fault_d = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    ram_en  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q == '0) begin
                    // A protected write still completes normally, flagged via fault.
                    if (prot_hit) begin
                        fault_d = 1'b1;
                    end else begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (op_rd_q) begin
                    rdata_d = ram_dout;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_rd_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_rd_q <= op_rd_d;
            fault_q <= fault_d;
        end
    end

    ram_sp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk   (clk),
        .en_i  (ram_en),
        .we_i  (ram_we),
        .addr_i(addr_q),
        .din_i (wdata_q),
        .dout_o(ram_dout)
    );

    // Fresh read data comes straight from the RAM in the done cycle, then is held.
    assign rdata   = (state_q == ST_RESP && op_rd_q) ? ram_dout : rdata_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_RESP);
    assign fault   = fault_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default instance plus a WR_LAT=3 instance for abort.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, read, write, busy, done, fault;
    logic [8:0]  addr;
    logic [31:0] wdata, rdata;
    logic [1:0]  state;
    logic        clr3, read3, write3, busy3, done3, fault3;
    logic [8:0]  addr3;
    logic [31:0] wdata3, rdata3;
    logic [1:0]  state3;

    mem_responder dut (
        .clk(clk), .clr(clr), .read(read), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .fault(fault), .state_o(state)
    );

    mem_responder #(.WR_LAT(3)) dut3 (
        .clk(clk), .clr(clr3), .read(read3), .write(write3), .addr(addr3), .wdata(wdata3),
        .rdata(rdata3), .busy(busy3), .done(done3), .fault(fault3), .state_o(state3)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [8:0] a, input logic [31:0] d);
        if (sel) begin
            read3 = r; write3 = w; addr3 = a; wdata3 = d;
        end else begin
            read = r; write = w; addr = a; wdata = d;
        end
    endtask

    function automatic logic done_s(input bit sel);
        return sel ? done3 : done;
    endfunction
    function automatic logic busy_s(input bit sel);
        return sel ? busy3 : busy;
    endfunction
    function automatic logic fault_s(input bit sel);
        return sel ? fault3 : fault;
    endfunction
    function automatic logic [31:0] rdata_s(input bit sel);
        return sel ? rdata3 : rdata;
    endfunction

    // One request; lat = cycles from accept edge to the done cycle.
    // Unless hold, the strobe drops after accept and addr/wdata are scrambled.
    task automatic op(input bit sel, input bit is_wr, input logic [8:0] a,
                      input logic [31:0] d, input bit hold, output logic [31:0] rd,
                      output int lat, output bit flt_any, output bit flt_done);
        int  cyc;
        bit  got;
        cyc = 0; got = 0; lat = -1; rd = '0; flt_any = 0; flt_done = 0;
        drive(sel, !is_wr, is_wr, a, d);
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check("busy_after_accept", 32'(busy_s(sel)), 32'd1);
                if (!hold) drive(sel, 1'b0, 1'b0, ~a, ~d);
            end
            flt_any |= fault_s(sel);
            if (done_s(sel)) begin
                got      = 1;
                lat      = cyc - 1;
                rd       = rdata_s(sel);
                flt_done = fault_s(sel);
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    int          lat;
    bit          fa, fd, seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; clr3 = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_rdata3", rdata3, 32'd0);
        clr = 1'b0; clr3 = 1'b0;
        @(posedge clk); #1;

        // Write then read back address 5
        op(0, 1, 9'd5, 32'hDEADBEEF, 0, rd, lat, fa, fd);
        check("wr5_lat", 32'(lat), 32'd1);
        check("wr5_fault", 32'(fa), 32'd0);
        op(0, 0, 9'd5, 32'h0, 1, rd, lat, fa, fd);
        check("rd5_lat", 32'(lat), 32'd2);
        check("rd5_data", rd, 32'hDEADBEEF);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            seen |= done;
        end
        check("held_read_no_redone", 32'(seen), 32'd0);
        check("rdata_holds", rdata, 32'hDEADBEEF);
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1;

        // Simultaneous read and write
        drive(0, 1, 1, 9'd5, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("rw_fault", 32'(fault), 32'd1);
        check("rw_busy", 32'(busy), 32'd0);
        seen = done;
        @(posedge clk); #1;
        check("rw_fault_pulse", 32'(fault), 32'd0);
        repeat (3) begin
            seen |= done;
            @(posedge clk); #1;
        end
        check("rw_no_done", 32'(seen), 32'd0);
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        op(0, 0, 9'd5, 32'h0, 0, rd, lat, fa, fd);
        check("rw_ram5_unchanged", rd, 32'hDEADBEEF);

        // Top and bottom addresses
        op(0, 1, 9'd0, 32'hA5A50000, 0, rd, lat, fa, fd);
        op(0, 1, 9'd511, 32'h12345678, 0, rd, lat, fa, fd);
        op(0, 0, 9'd511, 32'h0, 0, rd, lat, fa, fd);
        check("rd511", rd, 32'h12345678);
        op(0, 0, 9'd0, 32'h0, 0, rd, lat, fa, fd);
        check("rd0_no_alias", rd, 32'hA5A50000);

`ifdef MEM_PROT_EN
        dut.u_ram.mem[3] = 32'h00000033;
        op(0, 1, 9'd3, 32'h0000FFFF, 0, rd, lat, fa, fd);
        check("prot_wr3_lat", 32'(lat), 32'd1);
        check("prot_wr3_fault_at_done", 32'(fd), 32'd1);
        op(0, 0, 9'd3, 32'h0, 0, rd, lat, fa, fd);
        check("prot_rd3_old", rd, 32'h00000033);
`else
        op(0, 1, 9'd3, 32'h0000FFFF, 0, rd, lat, fa, fd);
        check("wr3_fault", 32'(fa), 32'd0);
        op(0, 0, 9'd3, 32'h0, 0, rd, lat, fa, fd);
        check("rd3", rd, 32'h0000FFFF);
`endif
        op(0, 1, 9'd16, 32'h0000BEEF, 0, rd, lat, fa, fd);
        check("wr16_fault", 32'(fa), 32'd0);
        op(0, 0, 9'd16, 32'h0, 0, rd, lat, fa, fd);
        check("rd16", rd, 32'h0000BEEF);

        // Abort an in-flight write on the WR_LAT=3 instance
        op(1, 1, 9'd7, 32'h0, 0, rd, lat, fa, fd);
        check("wr7_lat3", 32'(lat), 32'd3);
        drive(1, 0, 1, 9'd7, 32'h1);
        @(posedge clk); #1;
        check("abort_busy_pre", 32'(busy3), 32'd1);
        @(posedge clk); #1;
        check("abort_state_wrwait", 32'(state3), 32'(ST_WR_WAIT));
        clr3 = 1'b1;
        drive(1, 0, 0, '0, '0);
        #1;
        check("abort_busy", 32'(busy3), 32'd0);
        check("abort_done", 32'(done3), 32'd0);
        @(posedge clk); #1;
        clr3 = 1'b0;
        @(posedge clk); #1;
        op(1, 0, 9'd7, 32'h0, 0, rd, lat, fa, fd);
        check("abort_rd7_lat", 32'(lat), 32'd2);
        check("abort_rd7_data", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
